// File: rtl/match_controller.sv
// Match sequencer for a two-player fight: game ticks, rounds, scoring.
// Round timer is compiled in only with `define ROUND_TIMER_EN.
// Ports: clk, reset (sync, active-low), start, pause, gameOver1/2,
//   hp1/2 in; en (tick pulse), logic_rst, wins1/2, round_num,
//   timer, match_over, winner out.
module match_controller #(
  parameter int TICK_DIV     = 4,
  parameter int ROUND_TIME   = 99,
  parameter int WINS_NEEDED  = 2,
  parameter int PAUSE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       gameOver1,
  input  logic       gameOver2,
  input  logic [1:0] hp1,
  input  logic [1:0] hp2,
  output logic       en,
  output logic       logic_rst,
  output logic [1:0] wins1,
  output logic [1:0] wins2,
  output logic [2:0] round_num,
  output logic [6:0] timer,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(PAUSE_CYCLES + 1);

  if (TICK_DIV < 2 || PAUSE_CYCLES < 1 ||
      WINS_NEEDED < 1 || WINS_NEEDED > 3 ||
      ROUND_TIME < 1 || ROUND_TIME > 127) begin : g_bad_param
    $error("match_controller: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    ROUND_INIT,
    FIGHT,
    ROUND_END,
    MATCH_OVER
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [1:0]    wins1_q, wins1_d;
  logic [1:0]    wins2_q, wins2_d;
  logic [2:0]    rnd_q, rnd_d;
  logic          ko;
  logic          tick;
  logic          done;

  function automatic logic [1:0] inc_sat(input logic [1:0] w);
    return (w == 2'd3) ? w : w + 2'd1;
  endfunction

  assign ko   = gameOver1 | gameOver2;
  assign tick = (cnt_q == TW'(TICK_DIV - 1));
  assign done = (wins1_q == 2'(WINS_NEEDED)) ||
                (wins2_q == 2'(WINS_NEEDED));

  // A KO sampled this clock suppresses the tick that would
  // otherwise coincide with it.
  assign en = (state_q == FIGHT) && !pause && !ko && tick;

  assign logic_rst  = (state_q != FIGHT);
  assign match_over = (state_q == MATCH_OVER);
  assign wins1      = wins1_q;
  assign wins2      = wins2_q;
  assign round_num  = rnd_q;

`ifdef ROUND_TIMER_EN
  logic [6:0] timer_q, timer_d;
  logic       tout;
  // Final tick of the round; KO takes priority since en is
  // already masked by ko.
  assign tout  = en && (timer_q == 7'd1);
  assign timer = timer_q;
`else
  logic unused_hp;
  assign unused_hp = ^{hp1, hp2};
  assign timer     = 7'd0;
`endif

  always_comb begin
    winner = 2'b00;
    unique case (1'b1)
      match_over && wins1_q == 2'(WINS_NEEDED): winner = 2'b01;
      match_over && wins2_q == 2'(WINS_NEEDED): winner = 2'b10;
      default: winner = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    wins1_d = wins1_q;
    wins2_d = wins2_q;
    rnd_d   = rnd_q;
`ifdef ROUND_TIMER_EN
    timer_d = timer_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ROUND_INIT;
      end
      ROUND_INIT: begin
        cnt_d   = '0;
        rnd_d   = (rnd_q == 3'd7) ? rnd_q : rnd_q + 3'd1;
        state_d = FIGHT;
`ifdef ROUND_TIMER_EN
        timer_d = 7'(ROUND_TIME);
`endif
      end
      FIGHT: begin
        if (!pause) cnt_d = tick ? '0 : cnt_q + TW'(1);
        if (ko) begin
          state_d = ROUND_END;
          pc_d    = '0;
          // The player who is not KO'd scores; double KO is a draw.
          if (!gameOver1) wins1_d = inc_sat(wins1_q);
          if (!gameOver2) wins2_d = inc_sat(wins2_q);
        end
`ifdef ROUND_TIMER_EN
        else if (en) begin
          timer_d = timer_q - 7'd1;
          if (tout) begin
            state_d = ROUND_END;
            pc_d    = '0;
            if (hp1 > hp2) wins1_d = inc_sat(wins1_q);
            else if (hp2 > hp1) wins2_d = inc_sat(wins2_q);
          end
        end
`endif
      end
      ROUND_END: begin
        if (pc_q == PW'(PAUSE_CYCLES - 1)) begin
          state_d = done ? MATCH_OVER : ROUND_INIT;
        end else begin
          pc_d = pc_q + PW'(1);
        end
      end
      MATCH_OVER: begin
        if (start) begin
          wins1_d = '0;
          wins2_d = '0;
          rnd_d   = '0;
          state_d = ROUND_INIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      wins1_q <= '0;
      wins2_q <= '0;
      rnd_q   <= '0;
`ifdef ROUND_TIMER_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      wins1_q <= wins1_d;
      wins2_q <= wins2_d;
      rnd_q   <= rnd_d;
`ifdef ROUND_TIMER_EN
      timer_q <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller.
// Timeout scenarios run on a second instance with ROUND_TIMER_EN.
module tb_match_controller;

`ifdef ROUND_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       gameOver1 = 1'b0;
  logic       gameOver2 = 1'b0;
  logic [1:0] hp1 = 2'd0;
  logic [1:0] hp2 = 2'd0;
  logic       en, logic_rst, match_over;
  logic [1:0] wins1, wins2, winner;
  logic [2:0] round_num;
  logic [6:0] timer;

  int checks = 0;
  int failures = 0;

  // {en, timer} expectations and {wins1, wins2} expectations
  logic [7:0] exp_q[$];
  logic [3:0] sc_q[$];
  logic [7:0] e8;
  logic [3:0] e4;

  always #5 clk = ~clk;

  match_controller #(
    .TICK_DIV(4), .ROUND_TIME(99),
    .WINS_NEEDED(2), .PAUSE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .gameOver1(gameOver1), .gameOver2(gameOver2),
    .hp1(hp1), .hp2(hp2), .en(en), .logic_rst(logic_rst),
    .wins1(wins1), .wins2(wins2), .round_num(round_num),
    .timer(timer), .match_over(match_over), .winner(winner)
  );

`ifdef ROUND_TIMER_EN
  logic       t_en, t_rst, t_mo;
  logic [1:0] t_w1, t_w2, t_win;
  logic [2:0] t_rnd;
  logic [6:0] t_timer;

  match_controller #(
    .TICK_DIV(4), .ROUND_TIME(3),
    .WINS_NEEDED(2), .PAUSE_CYCLES(8)
  ) u_t (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .gameOver1(gameOver1), .gameOver2(gameOver2),
    .hp1(hp1), .hp2(hp2), .en(t_en), .logic_rst(t_rst),
    .wins1(t_w1), .wins2(t_w2), .round_num(t_rnd),
    .timer(t_timer), .match_over(t_mo), .winner(t_win)
  );
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Advance n clocks, counting en pulses and logic_rst lows.
  task automatic run(input int n, output int ens, output int lows);
    ens = 0;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (en === 1'b1) ens++;
      if (logic_rst !== 1'b1) lows++;
    end
  endtask

  task automatic test_reset();
    int ens, lows;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({en, logic_rst, match_over} !== 3'b010) begin
      failures++;
      $display("FAIL rst_ctl got=%b exp=010",
               {en, logic_rst, match_over});
    end
    checks++;
    if ({wins1, wins2, round_num, winner} !== 9'd0) begin
      failures++;
      $display("FAIL rst_cnt got=%h exp=0",
               {wins1, wins2, round_num, winner});
    end
    checks++;
    if (timer !== 7'd0) begin
      failures++;
      $display("FAIL rst_timer got=%0d exp=0", timer);
    end
    reset = 1'b1;
    run(3, ens, lows);
    checks++;
    if (ens != 0 || lows != 0 || round_num !== 3'd0) begin
      failures++;
      $display("FAIL idle_hold en=%0d low=%0d rnd=%0d exp=0,0,0",
               ens, lows, round_num);
    end
  endtask

  task automatic test_cadence();
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (logic_rst !== 1'b1 || en !== 1'b0) begin
      failures++;
      $display("FAIL init_rst rst=%b en=%b exp=1,0",
               logic_rst, en);
    end
    start = 1'b0;
    for (int k = 0; k < 16; k++)
      exp_q.push_back({k % 4 == 3,
                       TMR ? 7'(99 - k / 4) : 7'd0});
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e8 = exp_q.pop_front();
      checks++;
      if (en !== e8[7] || timer !== e8[6:0]) begin
        failures++;
        $display("FAIL cadence k=%0d en=%b t=%0d exp=%b,%0d",
                 k, en, timer, e8[7], e8[6:0]);
      end
      if (k == 0) begin
        checks++;
        if (round_num !== 3'd1 || logic_rst !== 1'b0) begin
          failures++;
          $display("FAIL fight_entry rnd=%0d rst=%b exp=1,0",
                   round_num, logic_rst);
        end
      end
    end
  endtask

  task automatic test_match_win();
    int ens, lows;
    @(negedge clk);
    gameOver2 = 1'b1;
    sc_q.push_back({2'd1, 2'd0});
    @(negedge clk);
    gameOver2 = 1'b0;
    e4 = sc_q.pop_front();
    checks++;
    if ({wins1, wins2} !== e4 || logic_rst !== 1'b1) begin
      failures++;
      $display("FAIL win_r1 w=%h rst=%b exp=%h,1",
               {wins1, wins2}, logic_rst, e4);
    end
    run(7, ens, lows);
    checks++;
    if (ens != 0 || lows != 0 || match_over !== 1'b0) begin
      failures++;
      $display("FAIL rend_hold en=%0d low=%0d mo=%b exp=0,0,0",
               ens, lows, match_over);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (round_num !== 3'd2 || logic_rst !== 1'b0) begin
      failures++;
      $display("FAIL round2 rnd=%0d rst=%b exp=2,0",
               round_num, logic_rst);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (en !== 1'b1) begin
      failures++;
      $display("FAIL pre_ko_en got=%b exp=1", en);
    end
    gameOver2 = 1'b1;
    sc_q.push_back({2'd2, 2'd0});
    #1;
    checks++;
    if (en !== 1'b0) begin
      failures++;
      $display("FAIL ko_masks_en got=%b exp=0", en);
    end
    @(negedge clk);
    gameOver2 = 1'b0;
    e4 = sc_q.pop_front();
    checks++;
    if ({wins1, wins2} !== e4) begin
      failures++;
      $display("FAIL win_r2 got=%h exp=%h", {wins1, wins2}, e4);
    end
    run(7, ens, lows);
    checks++;
    if (match_over !== 1'b0 || ens != 0) begin
      failures++;
      $display("FAIL early_over mo=%b en=%0d exp=0,0",
               match_over, ens);
    end
    @(negedge clk);
    checks++;
    if ({match_over, winner, en, logic_rst} !== 5'b10101) begin
      failures++;
      $display("FAIL match_over got=%b exp=10101",
               {match_over, winner, en, logic_rst});
    end
    @(negedge clk);
    checks++;
    if (match_over !== 1'b1) begin
      failures++;
      $display("FAIL over_hold got=%b exp=1", match_over);
    end
  endtask

  task automatic test_draw();
    int ens, lows;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({wins1, wins2, round_num, winner, match_over} !== 10'd0)
    begin
      failures++;
      $display("FAIL restart_clear got=%h exp=0",
               {wins1, wins2, round_num, winner, match_over});
    end
    start = 1'b0;
    @(negedge clk);
    gameOver1 = 1'b1;
    gameOver2 = 1'b1;
    sc_q.push_back({2'd0, 2'd0});
    @(negedge clk);
    gameOver1 = 1'b0;
    gameOver2 = 1'b0;
    start = 1'b1;
    e4 = sc_q.pop_front();
    checks++;
    if ({wins1, wins2} !== e4 || logic_rst !== 1'b1) begin
      failures++;
      $display("FAIL draw_score w=%h rst=%b exp=%h,1",
               {wins1, wins2}, logic_rst, e4);
    end
    run(7, ens, lows);
    repeat (2) @(negedge clk);
    start = 1'b0;
    checks++;
    if (round_num !== 3'd2 || timer !== (TMR ? 7'd99 : 7'd0))
    begin
      failures++;
      $display("FAIL draw_next rnd=%0d t=%0d exp=2",
               round_num, timer);
    end
    for (int k = 0; k < 4; k++)
      exp_q.push_back({k == 3, 7'd0});
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      e8 = exp_q.pop_front();
      checks++;
      if (en !== e8[7]) begin
        failures++;
        $display("FAIL draw_cad k=%0d got=%b exp=%b",
                 k, en, e8[7]);
      end
    end
  endtask

  task automatic test_pause();
    int ens;
    int tbad;
    logic [6:0] th;
    int eny, lows;
    @(negedge clk);
    th = TMR ? 7'd98 : 7'd0;
    pause = 1'b1;
    ens = 0;
    tbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (en !== 1'b0) ens++;
      if (timer !== th) tbad++;
    end
    checks++;
    if (ens != 0 || tbad != 0) begin
      failures++;
      $display("FAIL pause_hold en=%0d tbad=%0d exp=0,0",
               ens, tbad);
    end
    pause = 1'b0;
    for (int k = 0; k < 8; k++)
      exp_q.push_back({k == 2 || k == 6, 7'd0});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e8 = exp_q.pop_front();
      checks++;
      if (en !== e8[7]) begin
        failures++;
        $display("FAIL resume k=%0d got=%b exp=%b",
                 k, en, e8[7]);
      end
    end
    checks++;
    if (timer !== (TMR ? 7'd96 : 7'd0)) begin
      failures++;
      $display("FAIL resume_timer got=%0d", timer);
    end
    gameOver1 = 1'b1;
    sc_q.push_back({2'd0, 2'd1});
    @(negedge clk);
    gameOver1 = 1'b0;
    e4 = sc_q.pop_front();
    checks++;
    if ({wins1, wins2} !== e4) begin
      failures++;
      $display("FAIL p2_score got=%h exp=%h", {wins1, wins2}, e4);
    end
    run(7, eny, lows);
    repeat (2) @(negedge clk);
    gameOver2 = 1'b1;
    sc_q.push_back({2'd1, 2'd1});
    @(negedge clk);
    gameOver2 = 1'b0;
    e4 = sc_q.pop_front();
    checks++;
    if ({wins1, wins2} !== e4) begin
      failures++;
      $display("FAIL p1_score got=%h exp=%h", {wins1, wins2}, e4);
    end
    run(7, eny, lows);
    checks++;
    if (match_over !== 1'b0) begin
      failures++;
      $display("FAIL one_one_over got=%b exp=0", match_over);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (round_num !== 3'd4) begin
      failures++;
      $display("FAIL round4 got=%0d exp=4", round_num);
    end
  endtask

  task automatic test_reset_mid();
    int ens, lows;
    @(negedge clk);
    checks++;
    if (wins1 !== 2'd1 || logic_rst !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset w1=%0d rst=%b exp=1,0",
               wins1, logic_rst);
    end
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({en, logic_rst, match_over, winner} !== 5'b01000) begin
      failures++;
      $display("FAIL mid_rst_ctl got=%b exp=01000",
               {en, logic_rst, match_over, winner});
    end
    checks++;
    if ({wins1, wins2, round_num, timer} !== 14'd0) begin
      failures++;
      $display("FAIL mid_rst_cnt got=%h exp=0",
               {wins1, wins2, round_num, timer});
    end
    reset = 1'b1;
    start = 1'b0;
    run(3, ens, lows);
    checks++;
    if (ens != 0 || lows != 0 || round_num !== 3'd0) begin
      failures++;
      $display("FAIL post_rst en=%0d low=%0d rnd=%0d exp=0,0,0",
               ens, lows, round_num);
    end
  endtask

`ifdef ROUND_TIMER_EN
  task automatic test_timeout();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hp1 = 2'd3;
    hp2 = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 12; k++)
      exp_q.push_back({k % 4 == 3, 7'(3 - k / 4)});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e8 = exp_q.pop_front();
      checks++;
      if (t_en !== e8[7] || t_timer !== e8[6:0]) begin
        failures++;
        $display("FAIL tmo_cad k=%0d en=%b t=%0d exp=%b,%0d",
                 k, t_en, t_timer, e8[7], e8[6:0]);
      end
    end
    sc_q.push_back({2'd1, 2'd0});
    @(negedge clk);
    e4 = sc_q.pop_front();
    checks++;
    if ({t_w1, t_w2} !== e4 || t_rst !== 1'b1 ||
        t_timer !== 7'd0) begin
      failures++;
      $display("FAIL tmo_win w=%h rst=%b t=%0d exp=%h,1,0",
               {t_w1, t_w2}, t_rst, t_timer, e4);
    end
    hp1 = 2'd2;
    hp2 = 2'd2;
    repeat (8) @(negedge clk);
    repeat (12) @(negedge clk);
    sc_q.push_back({2'd1, 2'd0});
    @(negedge clk);
    e4 = sc_q.pop_front();
    checks++;
    if ({t_w1, t_w2} !== e4 || t_rst !== 1'b1) begin
      failures++;
      $display("FAIL tmo_draw w=%h rst=%b exp=%h,1",
               {t_w1, t_w2}, t_rst, e4);
    end
    hp1 = 2'd3;
    hp2 = 2'd1;
    repeat (8) @(negedge clk);
    repeat (12) @(negedge clk);
    gameOver1 = 1'b1;
    sc_q.push_back({2'd1, 2'd1});
    @(negedge clk);
    gameOver1 = 1'b0;
    e4 = sc_q.pop_front();
    checks++;
    if ({t_w1, t_w2} !== e4) begin
      failures++;
      $display("FAIL tmo_ko_prio got=%h exp=%h",
               {t_w1, t_w2}, e4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cadence();
    test_match_win();
    test_draw();
    test_pause();
    test_reset_mid();
`ifdef ROUND_TIMER_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clocks per game tick (legal range >= 2).
REQ-002 SHALL have parameter ROUND_TIME, default 99: game ticks per round, 7-bit range 1..127.
REQ-003 SHALL have parameter WINS_NEEDED, default 2: round wins that end the match, range 1..3.
REQ-004 SHALL have parameter PAUSE_CYCLES, default 8: ROUND_END hold length in clocks, range >= 1.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on posedge clk.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: level, sampled each clock; begins a match from IDLE or MATCH_OVER.
REQ-008 SHALL have port pause, input, 1: level; freezes play while high during FIGHT.
REQ-009 SHALL have ports gameOver1 and gameOver2, inputs, 1 each: player-KO flags from the fight datapath.
REQ-010 SHALL have ports hp1 and hp2, inputs, 2 each: player health from the fight datapath.
REQ-011 SHALL have port en, output, 1: one-clock game-tick enable to the fight datapath.
REQ-012 SHALL have port logic_rst, output, 1: active-high round reset to the fight datapath.
REQ-013 SHALL have ports wins1 and wins2, outputs, 2 each: round wins per player.
REQ-014 SHALL have port round_num, output, 3: current round number, 1-based.
REQ-015 SHALL have port timer, output, 7: game ticks remaining in the round.
REQ-016 SHALL have port match_over, output, 1: high in MATCH_OVER.
REQ-017 SHALL have port winner, output, 2: 00 = none, 01 = player 1, 10 = player 2; valid while match_over is high.

Function
REQ-018 SHALL implement the FSM IDLE -> ROUND_INIT -> FIGHT -> ROUND_END -> (ROUND_INIT | MATCH_OVER); leave IDLE only when start=1.
REQ-019 SHALL, in ROUND_INIT (exactly 1 clock): assert logic_rst, clear the tick counter, load timer=ROUND_TIME, increment round_num (saturating at 7), then go to FIGHT.
REQ-020 SHALL, in FIGHT: count tick counter 0..TICK_DIV-1 and wrap; pulse en for 1 clock when the counter equals TICK_DIV-1; decrement timer on each en.
REQ-021 SHALL, while pause=1 in FIGHT: hold the tick counter and timer, and keep en=0.
REQ-022 SHALL exit FIGHT to ROUND_END the clock after gameOver1 or gameOver2 is sampled high; no further en pulse after that sample.
REQ-023 SHALL score on ROUND_END entry: only gameOver2 -> wins1+1; only gameOver1 -> wins2+1; both -> draw, no increment; wins saturate at 3.
REQ-024 SHALL hold ROUND_END for PAUSE_CYCLES clocks with logic_rst=1 and en=0.
REQ-025 SHALL, at the end of ROUND_END: go to MATCH_OVER if either wins equals WINS_NEEDED, otherwise go to ROUND_INIT.
REQ-026 SHALL, in MATCH_OVER: set match_over=1 and winner to the player holding WINS_NEEDED wins, with en=0 and logic_rst=1.
REQ-027 SHALL, on start=1 in MATCH_OVER: clear wins1, wins2, round_num and winner, then enter ROUND_INIT.
REQ-028 SHALL ignore start in ROUND_INIT, FIGHT and ROUND_END.
REQ-029 SHALL hold logic_rst=1 in IDLE.

Reset
REQ-030 SHALL, when reset=0 at a clock edge, override every other input and force: state=IDLE, en=0, logic_rst=1, wins1=wins2=0, round_num=0, timer=0, match_over=0, winner=00, tick counter=0.
REQ-031 SHALL, on reset mid-FIGHT or mid-ROUND_END, discard the current round with no score update.

Configuration
REQ-032 SHALL compile in the round timer only when macro ROUND_TIMER_EN is defined.
REQ-033 SHALL, with ROUND_TIMER_EN defined: on timer reaching 0 in FIGHT, go to ROUND_END; higher hp wins the round, equal hp is a draw.
REQ-034 SHALL, on the same clock as a timeout, give KO flags (gameOver1/gameOver2) priority over the timer result.
REQ-035 SHALL, without ROUND_TIMER_EN: hold timer at 0, end a round only by KO, and include no timer logic.

Verification
REQ-036 SHALL cover tick cadence: TICK_DIV=4, start pulse -> logic_rst high for 1 clock, then en high every 4th clock; timer counts 99, 98, ...
REQ-037 SHALL cover a match win: gameOver2 in rounds 1 and 2 -> wins1=1 then 2; match_over=1 and winner=01 after 8 ROUND_END clocks.
REQ-038 SHALL cover a draw: gameOver1=gameOver2=1 together -> wins unchanged, round_num advances to 2, play restarts.
REQ-039 SHALL cover pause: pause=1 for 20 clocks mid-FIGHT -> no en pulses, timer constant; cadence resumes from the held counter.
REQ-040 SHALL cover timeout (ROUND_TIMER_EN, ROUND_TIME=3): hp1=3, hp2=1, no KO -> ROUND_END after 3 en pulses and wins1=1; repeat with hp1=hp2=2 -> draw.
REQ-041 SHALL cover reset: reset=0 mid-FIGHT with wins1=1 -> next clock all outputs at reset values, state IDLE.
